mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Sequencer/arbiter that shares one Add_Shift_Mult instance between N requesters.
- Each requester presents operands with a req/gnt handshake. The arbiter picks a winner round-robin, latches its operands, pulses the multiplier start and waits for completion.
- The result is returned with a one-cycle done pulse addressed to the owner.
- Sits between client FSMs and the multiplier. The multiplier ports connect one-to-one.

Parameters:
- N, 3, number of requesters (2..8)
- W, 4, operand width; result width is 2W
- WDOG_CYCLES, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  N  per-requester request level
- a_in  in  N*W  packed A operands; requester i at bits [i*W +: W]
- b_in  in  N*W  packed B operands, same packing as a_in
- gnt  out  N  one-hot, one-cycle pulse: operands captured
- done  out  N  one-hot, one-cycle pulse: result valid for that requester
- result  out  2W  last completed product, held until the next done
- busy  out  1  high whenever state is not IDLE
- mult_start  out  1  start pulse to the multiplier
- mult_a  out  W  latched A operand
- mult_b  out  W  latched B operand
- mult_result  in  2W  multiplier result bus
- mult_ready  in  1  multiplier ready (high = idle/result valid)

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - gnt, done, result, mult_start, mult_a and mult_b are all 0; busy=0.
  - RR pointer last=N-1, so requester 0 has first priority.
- States: IDLE, WAIT_LOW, WAIT_HIGH.
- IDLE with req!=0 at an edge:
  - winner = first set bit of req scanning last+1, last+2, … modulo N.
  - Registered in the same edge: gnt<=onehot(winner), mult_a/mult_b<=winner's operands, mult_start<=1, owner<=winner, last<=winner.
  - Next state = WAIT_LOW.
- IDLE with req==0: stay; all pulses 0.
- gnt and mult_start are high for exactly one cycle; both are cleared on the following edge.
- WAIT_LOW: stay until mult_ready==0 (multiplier accepted), then go to WAIT_HIGH.
- WAIT_HIGH: on an edge with mult_ready==1:
  - result<=mult_result, done<=onehot(owner), state<=IDLE.
  - done is high for one cycle only.
- mult_a/mult_b are held stable from grant until the next grant.
- Requester protocol:
  - Hold req high with stable operands until gnt is seen; req may drop after gnt.
  - A requester that drops req before gnt is simply not served.
- req from any requester, including the owner, is ignored while busy. It is re-evaluated in IDLE.
- Back-to-back operation:
  - The done cycle coincides with the return to IDLE.
  - The next grant is registered at the edge after done, at the earliest. There are no idle bubbles beyond that.
- Fairness: with all req held high, grants rotate 0,1,2,0,… Each requester waits at most N-1 operations.
- Reset mid-operation:
  - The operation is discarded: no done and no result update.
  - Outputs take their reset values on the same edge.
- Width: result is exactly 2W bits copied from mult_result. The arbiter performs no arithmetic.

Optional Feature:
- Macro: MULT_SHARE_ARB_WDOG_EN.
- Defined:
  - Adds output err (1 bit) and a cycle counter covering WAIT_LOW plus WAIT_HIGH.
  - If the counter reaches WDOG_CYCLES, the operation is aborted: done<=onehot(owner), err<=1 (same one-cycle pulse as done), result<=0, state<=IDLE.
  - Normal completion pulses done with err=0.
  - The counter is cleared at each grant and by rst.
- Not defined: no err port and no counter. The arbiter waits indefinitely in WAIT_LOW/WAIT_HIGH.

Decomposition:
- Package mult_share_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_WAIT_LOW=2'd1, ST_WAIT_HIGH=2'd2;
  - default N/W/WDOG_CYCLES values.
- Sub-module mult_rr_pick (combinational):
  - inputs req[N], last index;
  - outputs winner index and valid;
  - instantiated once.

Test Plan:
- Reset behaviour: rst=1 for one edge mid-idle → all outputs 0, busy=0. Then req0 with A=3, B=2 → gnt[0] pulse, mult_start one cycle, done[0] pulse, result=6.
- Contention: req0 (A=6, B=8) and req2 (A=12, B=7) raised in the same cycle → requester 0 is served first (done[0], result=48). Requester 2 is granted at the edge after that done and gets done[2] with result=84.
- Round-robin fairness: all three req held high, operands 15×15, 1×1, 0×9 → done order 0,1,2,0 with results 225, 1, 0, 225. The grant after each done follows at the next edge.
- Request withdrawal and busy: req1 raised then dropped before gnt while busy with requester 0 → requester 1 is never granted, and gnt never fires during busy.
- Reset mid-operation: rst asserted during WAIT_HIGH → no done pulse, result keeps its reset value 0, mult_start=0. A new request after reset completes normally.
- Watchdog (MULT_SHARE_ARB_WDOG_EN, WDOG_CYCLES=8): a multiplier model holds mult_ready low after start → done plus err pulse exactly 8 cycles after the grant, result=0, busy=0 afterwards.

Source files
------------

// File: rtl/mult_share_arb_pkg.sv
// Shared-multiplier arbiter: FSM state encoding, default sizing and index-width helper.
package mult_share_arb_pkg;

   localparam int unsigned DEF_N           = 3;
   localparam int unsigned DEF_W           = 4;
   localparam int unsigned DEF_WDOG_CYCLES = 64;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_LOW  = 2'd1,
      ST_WAIT_HIGH = 2'd2
   } state_t;

   // Width of an index into n items; never zero so N=1-style corners still elaborate.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 32'd1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side bundle of the shared-multiplier arbiter (clients are master, arbiter is slave).
interface mult_share_arbiter_if
   import mult_share_arb_pkg::*;
#(
   parameter int unsigned N = DEF_N,
   parameter int unsigned W = DEF_W
);

   logic [N-1:0]   req;
   logic [N*W-1:0] a_in;
   logic [N*W-1:0] b_in;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic [2*W-1:0] result;
   logic           busy;

   modport master (
      output req, a_in, b_in,
      input  gnt, done, result, busy
   );

   modport slave (
      input  req, a_in, b_in,
      output gnt, done, result, busy
   );

endinterface

// File: rtl/mult_rr_pick.sv
// Combinational round-robin pick: first set request after index last_i, wrapping modulo N.
module mult_rr_pick
   import mult_share_arb_pkg::*;
#(
   parameter  int unsigned N  = DEF_N,
   localparam int unsigned IW = idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [IW-1:0] winner_o,
   output logic          valid_o
);

   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         if (!valid_o && req_i[IW'((32'(last_i) + k) % N)]) begin
            valid_o  = 1'b1;
            winner_o = IW'((32'(last_i) + k) % N);
         end
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer sharing one Add_Shift_Mult between N requesters.
// Optional watchdog abort (err output) enabled by defining MULT_SHARE_ARB_WDOG_EN.
module mult_share_arbiter
   import mult_share_arb_pkg::*;
#(
   parameter int unsigned N           = DEF_N,
   parameter int unsigned W           = DEF_W,
   parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   mult_share_arbiter_if.slave  bus,
   output logic                 mult_start,
   output logic [W-1:0]         mult_a,
   output logic [W-1:0]         mult_b,
   input  logic [2*W-1:0]       mult_result,
`ifdef MULT_SHARE_ARB_WDOG_EN
   output logic                 err,
`endif
   input  logic                 mult_ready
);

   localparam int unsigned IW = idx_w(N);

   state_t          state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [N-1:0]    done_q, done_d;
   logic [2*W-1:0]  result_q, result_d;
   logic            start_q, start_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   last_q, last_d;

   logic [IW-1:0]   pick_winner;
   logic            pick_valid;
   logic [W-1:0]    a_arr [N];
   logic [W-1:0]    b_arr [N];

`ifdef MULT_SHARE_ARB_WDOG_EN
   localparam int unsigned   CW        = idx_w(WDOG_CYCLES);
   localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYCLES - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`else
   localparam int unsigned wdog_unused = WDOG_CYCLES;
`endif

   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign a_arr[g] = bus.a_in[g*W +: W];
      assign b_arr[g] = bus.b_in[g*W +: W];
   end

   mult_rr_pick #(.N(N)) u_pick (
      .req_i    (bus.req),
      .last_i   (last_q),
      .winner_o (pick_winner),
      .valid_o  (pick_valid)
   );

   always_comb begin
      state_d  = state_q;
      gnt_d    = '0;
      done_d   = '0;
      start_d  = 1'b0;
      result_d = result_q;
      a_d      = a_q;
      b_d      = b_q;
      owner_d  = owner_q;
      last_d   = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               gnt_d[pick_winner] = 1'b1;
               a_d     = a_arr[pick_winner];
               b_d     = b_arr[pick_winner];
               start_d = 1'b1;
               owner_d = pick_winner;
               last_d  = pick_winner;
               state_d = ST_WAIT_LOW;
            end
         end
         ST_WAIT_LOW: begin
            if (!mult_ready) state_d = ST_WAIT_HIGH;
         end
         ST_WAIT_HIGH: begin
            if (mult_ready) begin
               result_d        = mult_result;
               done_d[owner_q] = 1'b1;
               state_d         = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef MULT_SHARE_ARB_WDOG_EN
      // Normal completion on the same edge takes precedence over the abort.
      cnt_d = '0;
      err_d = 1'b0;
      if (state_q != ST_IDLE && state_d != ST_IDLE) begin
         if (cnt_q == WDOG_LAST) begin
            done_d[owner_q] = 1'b1;
            err_d           = 1'b1;
            result_d        = '0;
            state_d         = ST_IDLE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         done_q   <= '0;
         result_q <= '0;
         start_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         owner_q  <= '0;
         last_q   <= IW'(N - 1);
`ifdef MULT_SHARE_ARB_WDOG_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         start_q  <= start_d;
         a_q      <= a_d;
         b_q      <= b_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
`ifdef MULT_SHARE_ARB_WDOG_EN
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.busy   = (state_q != ST_IDLE);
   assign mult_start = start_q;
   assign mult_a     = a_q;
   assign mult_b     = b_q;
`ifdef MULT_SHARE_ARB_WDOG_EN
   assign err        = err_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: vector table, corner sequences and a randomized
// run against a transaction-level priority-queue model; watchdog case under MULT_SHARE_ARB_WDOG_EN.
module tb_mult_share_arbiter;
   import mult_share_arb_pkg::*;

   localparam int unsigned N  = 3;
   localparam int unsigned W  = 4;
   localparam int unsigned WD = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mult_share_arbiter_if #(.N(N), .W(W)) bus ();

   logic           mult_start;
   logic [W-1:0]   mult_a;
   logic [W-1:0]   mult_b;
   logic [2*W-1:0] mult_result = '0;
   logic           mult_ready  = 1'b1;
`ifdef MULT_SHARE_ARB_WDOG_EN
   logic           err;
`endif

   mult_share_arbiter #(.N(N), .W(W), .WDOG_CYCLES(WD)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .mult_start  (mult_start),
      .mult_a      (mult_a),
      .mult_b      (mult_b),
      .mult_result (mult_result),
`ifdef MULT_SHARE_ARB_WDOG_EN
      .err         (err),
`endif
      .mult_ready  (mult_ready)
   );

   // Multiplier model: ready drops after start, returns the product mlat+1 cycles later.
   int             mlat   = 0;
   bit             m_hang = 1'b0;
   int             m_cnt  = 0;
   logic [2*W-1:0] m_prod = '0;

   always @(posedge clk) begin
      if (rst) begin
         mult_ready <= 1'b1;
         m_cnt      <= 0;
      end else if (mult_start) begin
         mult_ready <= 1'b0;
         m_cnt      <= mlat;
         m_prod     <= mult_a * mult_b;
      end else if (!mult_ready && !m_hang) begin
         if (m_cnt == 0) begin
            mult_ready  <= 1'b1;
            mult_result <= m_prod;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   int errors = 0;
   int checks = 0;
   int prio[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int opnd(input logic [N*W-1:0] pk, input int i);
      return int'((pk >> (i * W)) & ((1 << W) - 1));
   endfunction

   // Reference priority order: head is the requester currently favoured.
   function automatic int ref_pick(input logic [N-1:0] r);
      foreach (prio[k]) if (r[prio[k]]) return prio[k];
      return -1;
   endfunction

   task automatic ref_grant(input int w);
      int x;
      for (int k = 0; k < N && prio[$] != w; k++) begin
         x = prio.pop_front();
         prio.push_back(x);
      end
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bus.req = '0;
      tick();
      rst = 1'b0;
      prio.delete();
      for (int i = 0; i < N; i++) prio.push_back(i);
      check("rst_gnt",    bus.gnt,    0);
      check("rst_done",   bus.done,   0);
      check("rst_result", bus.result, 0);
      check("rst_busy",   bus.busy,   0);
      check("rst_start",  mult_start, 0);
      check("rst_mult_a", mult_a,     0);
      check("rst_mult_b", mult_b,     0);
   endtask

   task automatic wait_done(input int drop_at, output int cyc);
      bit stray;
      stray = 1'b0;
      cyc   = 0;
      do begin
         tick();
         cyc++;
         if (cyc == 1) check("start_one_cycle", mult_start, 0);
         if (cyc == drop_at) bus.req = '0;
         if (bus.done == '0 && bus.gnt != '0) stray = 1'b1;
      end while (bus.done == '0 && cyc < 64);
      check("gnt_while_busy", stray, 0);
      check("done_arrives", bus.done != '0, 1);
   endtask

   typedef struct {
      bit             rst_first;
      logic [N-1:0]   req;
      logic [N*W-1:0] a;
      logic [N*W-1:0] b;
      int             win;
      int             res;
      int             lat;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int cyc;
      int w;
      int ea;
      int eb;
      bit flag;
      logic [N-1:0]   r;
      logic [N*W-1:0] an;
      logic [N*W-1:0] bn;

      bus.req  = '0;
      bus.a_in = '0;
      bus.b_in = '0;

      // Operands packed {req2, req1, req0}.
      vecs[0] = '{1'b1, 3'b001, {4'd0,  4'd0, 4'd3},  {4'd0, 4'd0, 4'd2},  0, 6,   0};
      vecs[1] = '{1'b1, 3'b101, {4'd12, 4'd0, 4'd6},  {4'd7, 4'd0, 4'd8},  0, 48,  2};
      vecs[2] = '{1'b0, 3'b100, {4'd12, 4'd0, 4'd6},  {4'd7, 4'd0, 4'd8},  2, 84,  1};
      vecs[3] = '{1'b1, 3'b111, {4'd0,  4'd1, 4'd15}, {4'd9, 4'd1, 4'd15}, 0, 225, 3};
      vecs[4] = '{1'b0, 3'b111, {4'd0,  4'd1, 4'd15}, {4'd9, 4'd1, 4'd15}, 1, 1,   0};
      vecs[5] = '{1'b0, 3'b111, {4'd0,  4'd1, 4'd15}, {4'd9, 4'd1, 4'd15}, 2, 0,   2};
      vecs[6] = '{1'b0, 3'b111, {4'd0,  4'd1, 4'd15}, {4'd9, 4'd1, 4'd15}, 0, 225, 1};

      do_reset();
      foreach (vecs[i]) begin
         if (vecs[i].rst_first) do_reset();
         bus.req  = vecs[i].req;
         bus.a_in = vecs[i].a;
         bus.b_in = vecs[i].b;
         mlat     = vecs[i].lat;
         tick();
         check("tbl_gnt",    bus.gnt,    oh(vecs[i].win));
         check("tbl_start",  mult_start, 1);
         check("tbl_busy",   bus.busy,   1);
         check("tbl_mult_a", mult_a, opnd(vecs[i].a, vecs[i].win));
         check("tbl_mult_b", mult_b, opnd(vecs[i].b, vecs[i].win));
         wait_done(-1, cyc);
         check("tbl_done",      bus.done,   oh(vecs[i].win));
         check("tbl_result",    bus.result, vecs[i].res);
         check("tbl_idle_done", bus.busy,   0);
         check("tbl_a_hold",    mult_a, opnd(vecs[i].a, vecs[i].win));
`ifdef MULT_SHARE_ARB_WDOG_EN
         check("tbl_err", err, 0);
`endif
      end

      // Withdrawal: requester 1 raises and drops req while requester 0 is served.
      do_reset();
      bus.req  = 3'b001;
      bus.a_in = {4'd0, 4'd4, 4'd5};
      bus.b_in = {4'd0, 4'd4, 4'd5};
      mlat     = 3;
      tick();
      check("wd_gnt", bus.gnt, 3'b001);
      bus.req = 3'b010;
      wait_done(3, cyc);
      check("wd_done",   bus.done,   3'b001);
      check("wd_result", bus.result, 25);
      flag = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus.gnt != '0 || bus.busy) flag = 1'b1;
      end
      check("wd_no_grant_1", flag, 0);

      // Reset while waiting for the multiplier result.
      do_reset();
      bus.req  = 3'b001;
      bus.a_in = {4'd0, 4'd0, 4'd7};
      bus.b_in = {4'd0, 4'd0, 4'd3};
      mlat     = 5;
      tick();
      check("mr_gnt", bus.gnt, 3'b001);
      bus.req = '0;
      tick();
      tick();
      tick();
      check("mr_busy_wait_high", bus.busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_done",   bus.done,   0);
      check("mr_result", bus.result, 0);
      check("mr_start",  mult_start, 0);
      check("mr_busy",   bus.busy,   0);
      flag = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.done != '0 || bus.result != '0) flag = 1'b1;
      end
      check("mr_no_late_done", flag, 0);
      bus.req  = 3'b100;
      bus.a_in = {4'd9, 4'd0, 4'd0};
      bus.b_in = {4'd9, 4'd0, 4'd0};
      mlat     = 1;
      tick();
      check("mr_regnt", bus.gnt, 3'b100);
      wait_done(-1, cyc);
      check("mr_redone",   bus.done,   3'b100);
      check("mr_reresult", bus.result, 81);

`ifdef MULT_SHARE_ARB_WDOG_EN
      // Multiplier never returns ready: watchdog aborts WD cycles after the grant.
      do_reset();
      m_hang   = 1'b1;
      bus.req  = 3'b001;
      bus.a_in = {4'd0, 4'd0, 4'd5};
      bus.b_in = {4'd0, 4'd0, 4'd6};
      tick();
      check("wdog_gnt", bus.gnt, 3'b001);
      bus.req = '0;
      wait_done(-1, cyc);
      check("wdog_latency", cyc,        WD);
      check("wdog_done",    bus.done,   3'b001);
      check("wdog_err",     err,        1);
      check("wdog_result",  bus.result, 0);
      check("wdog_busy",    bus.busy,   0);
      tick();
      check("wdog_err_pulse",  err,      0);
      check("wdog_done_pulse", bus.done, 0);
      m_hang = 1'b0;
`endif

      // Randomized traffic against the priority-queue reference.
      do_reset();
      for (int it = 0; it < 60; it++) begin
         r    = N'($urandom_range(0, (1 << N) - 1));
         an   = (N*W)'($urandom);
         bn   = (N*W)'($urandom);
         mlat = $urandom_range(0, 3);
         w    = ref_pick(r);
         bus.req  = r;
         bus.a_in = an;
         bus.b_in = bn;
         tick();
         if (w < 0) begin
            check("rnd_idle_gnt",  bus.gnt,  0);
            check("rnd_idle_busy", bus.busy, 0);
         end else begin
            ref_grant(w);
            ea = opnd(an, w);
            eb = opnd(bn, w);
            check("rnd_gnt",    bus.gnt, oh(w));
            check("rnd_mult_a", mult_a,  ea);
            check("rnd_mult_b", mult_b,  eb);
            bus.req = N'($urandom_range(0, (1 << N) - 1));
            wait_done(-1, cyc);
            check("rnd_done",   bus.done,   oh(w));
            check("rnd_result", bus.result, ea * eb);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
